traffic_light_multi: RTL and testbench

Parametrised N-road traffic-light controller: next generation of the two-road `trafficLight` block. Serves one primary road (road 0, rests in green) and up to seven sensor-actuated secondary roads in round-robin order. It has configurable phase durations, a fault mode that flashes all reds, and status outputs. It runs on the board's 10 MHz clock domain; the board top maps `light_RYG` onto LEDs and `fault`/`sensor` onto buttons/switches.

---
 rtl/traffic_light_pkg.sv | 18 +
 rtl/tick_prescaler.sv | 29 ++
 rtl/traffic_light_multi.sv | 157 +++++++++++++++
 tb/tb_traffic_light_multi.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_pkg.sv
// Shared state encoding and lamp patterns for the multi-road traffic-light controller.
package traffic_light_pkg;

    typedef enum logic [2:0] {
        ALLRED = 3'd0,
        GREEN  = 3'd1,
        YELLOW = 3'd2,
        FAULT  = 3'd3
    } state_t;

    typedef logic [2:0] ryg_t;

    localparam ryg_t RED = 3'b100;
    localparam ryg_t YEL = 3'b010;
    localparam ryg_t GRN = 3'b001;
    localparam ryg_t OFF = 3'b000;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-cycle tick every CLK_DIV cycles.
module tick_prescaler #(
    parameter int CLK_DIV = 10_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST);

    // clear restarts the count so a phase always begins on a fresh tick boundary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/traffic_light_multi.sv
// N-road traffic-light controller: road 0 rests in green, sensor-actuated secondaries
// are served in ascending round-robin order, with an all-red flashing fault mode.
module traffic_light_multi
    import traffic_light_pkg::*;
#(
    parameter int NUM_ROADS   = 4,
    parameter int CLK_DIV     = 10_000_000,
    parameter int GREEN_MIN_S = 10,
    parameter int GREEN_MAX_S = 30,
    parameter int YELLOW_S    = 3,
    parameter int ALLRED_S    = 1,
    localparam int ROAD_W     = $clog2(NUM_ROADS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_ROADS-1:0]   sensor,
    input  logic                   fault,
    output logic [3*NUM_ROADS-1:0] light_RYG,
    output logic [ROAD_W-1:0]      active_road,
    output logic [2:0]             state
);

    localparam int TCNT_W  = $clog2(GREEN_MAX_S + 1);
    localparam int LIGHT_W = 3 * NUM_ROADS;
    localparam logic [TCNT_W-1:0]  TCNT_SAT = '1;
    localparam logic [LIGHT_W-1:0] ALL_RED  = {NUM_ROADS{RED}};
    localparam logic [LIGHT_W-1:0] ALL_OFF  = {NUM_ROADS{OFF}};

    state_t               state_q, state_d;
    logic [NUM_ROADS-1:0] sensor_m, sensor_s;
    logic [NUM_ROADS-1:0] demand, demand_d;
    logic                 fault_m, fault_s;
    logic [TCNT_W-1:0]    tcnt;
    logic [ROAD_W-1:0]    next_road;
    logic                 tick, entering;

    // True when, counting a concurrent tick, at least `ticks` ticks will have elapsed after this edge.
    function automatic logic elapsed(input logic [TCNT_W-1:0] cnt, input logic tk, input int ticks);
        return (int'(cnt) >= ticks) || (tk && (int'(cnt) == ticks - 1));
    endfunction

    function automatic logic [LIGHT_W-1:0] lights_for(input logic [ROAD_W-1:0] road, input ryg_t ryg);
        logic [LIGHT_W-1:0] v;
        v = ALL_RED;
        for (int i = 0; i < NUM_ROADS; i++) begin
            if (i == int'(road)) v[3*i +: 3] = ryg;
        end
        return v;
    endfunction

    // Lowest demanding road above the one just served; secondaries never wrap past road 0.
    function automatic logic [ROAD_W-1:0] pick_next(input logic [ROAD_W-1:0] served,
                                                    input logic [NUM_ROADS-1:0] dem);
        logic [ROAD_W-1:0] r;
        r = '0;
        for (int j = NUM_ROADS - 1; j >= 1; j--) begin
            if (j > int'(served) && dem[j]) r = ROAD_W'(j);
        end
        return r;
    endfunction

    tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (entering),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sensor_m <= '0;
            sensor_s <= '0;
            fault_m  <= 1'b0;
            fault_s  <= 1'b0;
        end else begin
            sensor_m <= sensor;
            sensor_s <= sensor_m;
            fault_m  <= fault;
            fault_s  <= fault_m;
        end
    end

    always_comb begin
        state_d = state_q;
        if (fault_s) begin
            state_d = FAULT;
        end else begin
            case (state_q)
                ALLRED: if (elapsed(tcnt, tick, ALLRED_S)) state_d = GREEN;
                GREEN: begin
                    if (active_road == '0) begin
                        if (elapsed(tcnt, tick, GREEN_MIN_S) && (|demand[NUM_ROADS-1:1]))
                            state_d = YELLOW;
                    end else if (elapsed(tcnt, tick, GREEN_MAX_S) ||
                                 (elapsed(tcnt, tick, GREEN_MIN_S) && !sensor_s[active_road])) begin
                        state_d = YELLOW;
                    end
                end
                YELLOW: if (elapsed(tcnt, tick, YELLOW_S)) state_d = ALLRED;
                default: state_d = ALLRED;
            endcase
        end
        entering = (state_d != state_q);
    end

    // Clearing takes priority over a same-cycle sensor set.
    always_comb begin
        demand_d    = demand | sensor_s;
        demand_d[0] = 1'b0;
        if (entering && state_d == FAULT) begin
            demand_d = '0;
        end else if (entering && state_d == GREEN) begin
            demand_d[next_road] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ALLRED;
            active_road <= '0;
            next_road   <= '0;
            demand      <= '0;
            tcnt        <= '0;
            light_RYG   <= ALL_RED;
        end else begin
            state_q <= state_d;
            demand  <= demand_d;
            if (entering) begin
                tcnt <= '0;
            end else if (tick && tcnt != TCNT_SAT) begin
                tcnt <= tcnt + TCNT_W'(1);
            end
            if (entering) begin
                case (state_d)
                    GREEN: begin
                        active_road <= next_road;
                        light_RYG   <= lights_for(next_road, GRN);
                    end
                    YELLOW: light_RYG <= lights_for(active_road, YEL);
                    FAULT: begin
                        active_road <= '0;
                        light_RYG   <= ALL_RED;
                    end
                    default: begin
                        next_road <= (state_q == FAULT) ? '0 : pick_next(active_road, demand);
                        light_RYG <= ALL_RED;
                    end
                endcase
            end else if (state_q == FAULT && tick) begin
                light_RYG <= (light_RYG == ALL_RED) ? ALL_OFF : ALL_RED;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_traffic_light_multi.sv
// Scoreboard bench for traffic_light_multi: a time-based reference model queues the
// expected outputs every cycle and a monitor compares them against the DUT.
module tb_traffic_light_multi;

    localparam int NR   = 3;
    localparam int CD   = 4;
    localparam int GMIN = 2;
    localparam int GMAX = 5;
    localparam int YS   = 1;
    localparam int ARS  = 1;

    localparam int S_ALLRED = 0;
    localparam int S_GREEN  = 1;
    localparam int S_YELLOW = 2;
    localparam int S_FAULT  = 3;

    typedef struct {
        logic [3*NR-1:0] lights;
        logic [1:0]      road;
        logic [2:0]      st;
    } exp_t;

    typedef struct {
        bit ok;
        int id;
        int budget;
    } wait_rec_t;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [NR-1:0]   sensor = '0;
    logic            fault = 1'b0;
    logic [3*NR-1:0] light_RYG;
    logic [1:0]      active_road;
    logic [2:0]      state;

    exp_t      sb_q[$];
    wait_rec_t wait_q[$];
    int        tests = 0;
    int        fails = 0;

    traffic_light_multi #(
        .NUM_ROADS  (NR),
        .CLK_DIV    (CD),
        .GREEN_MIN_S(GMIN),
        .GREEN_MAX_S(GMAX),
        .YELLOW_S   (YS),
        .ALLRED_S   (ARS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sensor     (sensor),
        .fault      (fault),
        .light_RYG  (light_RYG),
        .active_road(active_road),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Reference model: phase timing from elapsed cycles since phase entry.
    int        m_state, m_road, m_next, m_entry, m_cyc;
    bit [NR-1:0] m_dem, s_h1, s_h2, s_now;
    bit        f_h1, f_h2, f_now;

    task model_reset();
        m_state = S_ALLRED;
        m_road  = 0;
        m_next  = 0;
        m_entry = 0;
        m_cyc   = 0;
        m_dem   = '0;
        s_h1 = '0; s_h2 = '0; s_now = '0;
        f_h1 = 0;  f_h2 = 0;  f_now = 0;
    endtask

    task model_step();
        int el;
        int nxt;
        bit [NR-1:0] nd;
        m_cyc++;
        s_now = s_h2; s_h2 = s_h1; s_h1 = sensor;
        f_now = f_h2; f_h2 = f_h1; f_h1 = fault;
        el  = (m_cyc - m_entry) / CD;
        nxt = m_state;
        if (f_now) nxt = S_FAULT;
        else begin
            case (m_state)
                S_ALLRED: if (el >= ARS) nxt = S_GREEN;
                S_GREEN: begin
                    if (m_road == 0) begin
                        if (el >= GMIN && m_dem[NR-1:1] != 0) nxt = S_YELLOW;
                    end else if (el >= GMAX || (el >= GMIN && !s_now[m_road])) nxt = S_YELLOW;
                end
                S_YELLOW: if (el >= YS) nxt = S_ALLRED;
                default: nxt = S_ALLRED;
            endcase
        end
        nd = m_dem | s_now;
        nd[0] = 1'b0;
        if (nxt == S_FAULT && m_state != S_FAULT) nd = '0;
        if (nxt == S_GREEN && m_state != S_GREEN) nd[m_next] = 1'b0;
        if (nxt != m_state) begin
            if (nxt == S_ALLRED) begin
                m_next = 0;
                if (m_state != S_FAULT)
                    for (int j = NR - 1; j > m_road; j--) if (m_dem[j]) m_next = j;
            end
            if (nxt == S_GREEN) m_road = m_next;
            if (nxt == S_FAULT) m_road = 0;
            m_entry = m_cyc;
            m_state = nxt;
        end
        m_dem = nd;
    endtask

    function automatic exp_t expect_now();
        exp_t e;
        logic [2:0] lamp;
        e.road = 2'(m_road);
        e.st   = 3'(m_state);
        for (int r = 0; r < NR; r++) begin
            lamp = 3'b100;
            if (m_state == S_FAULT)
                lamp = (((m_cyc - m_entry) / CD) % 2 == 0) ? 3'b100 : 3'b000;
            else if (m_state == S_GREEN && r == m_road) lamp = 3'b001;
            else if (m_state == S_YELLOW && r == m_road) lamp = 3'b010;
            e.lights[3*r +: 3] = lamp;
        end
        return e;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                model_reset();
                sb_q.delete();
            end else begin
                model_step();
            end
            sb_q.push_back(expect_now());
        end
    end

    // Monitor: owns the counters; pops one expectation per cycle plus any wait outcomes.
    initial begin
        exp_t e;
        wait_rec_t w;
        int cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            while (wait_q.size() > 0) begin
                w = wait_q.pop_front();
                tests++;
                if (!w.ok) begin
                    fails++;
                    $display("FAIL wait%0d: target state not reached within %0d cycles (state=%0d road=%0d)",
                             w.id, w.budget, state, active_road);
                end
            end
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                tests++;
                if (light_RYG !== e.lights || active_road !== e.road || state !== e.st) begin
                    fails++;
                    $display("FAIL outputs@cyc%0d: got lights=%b road=%0d state=%0d, expected lights=%b road=%0d state=%0d",
                             cyc, light_RYG, active_road, state, e.lights, e.road, e.st);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [NR-1:0] bits);
        @(negedge clk);
        sensor = bits;
        @(negedge clk);
        sensor = '0;
    endtask

    task automatic wait_for(input int st, input int road, input int budget, input int id);
        int n;
        wait_rec_t w;
        n = 0;
        while (!(state === 3'(st) && active_road === 2'(road)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        w.ok = (n < budget);
        w.id = id;
        w.budget = budget;
        wait_q.push_back(w);
    endtask

    initial begin
        int fault_left;
        int r;
        fault_left = 0;
        reset_n = 1'b0;
        idle(3);
        reset_n = 1'b1;
        idle(210);

        pulse(3'b100);
        idle(60);

        pulse(3'b110);
        idle(80);

        @(negedge clk);
        sensor = 3'b010;
        idle(60);
        sensor = '0;
        idle(60);

        pulse(3'b010);
        wait_for(S_GREEN, 1, 100, 1);
        idle(3);
        fault = 1'b1;
        idle(20);
        fault = 1'b0;
        idle(30);

        pulse(3'b100);
        wait_for(S_YELLOW, 0, 100, 2);
        @(posedge clk);
        #2 reset_n = 1'b0;
        idle(3);
        reset_n = 1'b1;
        idle(30);

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            r = $urandom_range(0, 99);
            if (fault_left > 0) begin
                fault_left--;
                if (fault_left == 0) fault = 1'b0;
            end else if (r == 0) begin
                fault = 1'b1;
                fault_left = $urandom_range(1, 25);
            end
            sensor = '0;
            for (int b = 0; b < NR; b++) if ($urandom_range(0, 19) == 0) sensor[b] = 1'b1;
            if ((i % 400) < 45) sensor[1] = 1'b1;
            if ((i % 500) >= 250 && (i % 500) < 290) sensor[2] = 1'b1;
        end
        fault  = 1'b0;
        sensor = '0;
        idle(20);
        @(posedge clk);
        #3 $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
